// File: rtl/wine_pkg.sv
// wine_pkg: field offsets, FSM states and IPv4 constants shared by the composer and dispenser
package wine_pkg;
  localparam int SRC_MAC_HI   = 511;
  localparam int DST_MAC_HI   = 463;
  localparam int ETH_TYPE_HI  = 415;
  localparam int VER_IHL_HI   = 399;
  localparam int PKT_SIZE_HI  = 383;
  localparam int IP_TAG_HI    = 367;
  localparam int IP_FLAG_HI   = 351;
  localparam int TTL_HI       = 335;
  localparam int IP_PROTO_HI  = 327;
  localparam int IP_CSUM_HI   = 319;
  localparam int IP_SRC_HI    = 303;
  localparam int IP_DST_HI    = 271;
  localparam int SRC_PORT_HI  = 239;
  localparam int DST_PORT_HI  = 223;
  localparam int TCP_SEQ_HI   = 207;
  localparam int TCP_ACK_HI   = 175;
  localparam int TCP_HEAD_HI  = 143;
  localparam int TCP_FLAG_HI  = 133;
  localparam int TCP_WIND_HI  = 127;
  localparam int TCP_CSUM_HI  = 111;
  localparam int TCP_URG_HI   = 95;
  localparam int PAYLOAD_HI   = 79;
  localparam logic [7:0] IPV4_VER_IHL = 8'h45;
  localparam logic [2:0] IP_FLAG_DF = 3'b010;
  typedef enum logic [1:0] {ST_IDLE, ST_SUM, ST_FOLD, ST_OUT} state_e;
endpackage

// File: rtl/wine_packet_composer_if.sv
// wine_packet_composer_if: field input handshake and packet output handshake
interface wine_packet_composer_if;
  logic i_valid;
  logic i_ready;
  logic [103:0] ip_tuple;
  logic [15:0] pkt_size;
  logic [31:0] tcp_seq;
  logic [31:0] tcp_ack;
  logic [7:0] tcp_flag;
  logic [15:0] tcp_wind_size;
  logic [79:0] payload;
  logic o_valid;
  logic o_ready;
  logic [511:0] o_packet;
  modport master (
    output i_valid, ip_tuple, pkt_size, tcp_seq, tcp_ack, tcp_flag, tcp_wind_size, payload, o_ready,
    input i_ready, o_valid, o_packet
  );
  modport slave (
    input i_valid, ip_tuple, pkt_size, tcp_seq, tcp_ack, tcp_flag, tcp_wind_size, payload, o_ready,
    output i_ready, o_valid, o_packet
  );
endinterface

// File: rtl/wine_csum_acc.sv
// wine_csum_acc: 20-bit header word accumulator with ones'-complement fold
module wine_csum_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic add_en,
  input  logic [15:0] word,
  output logic [15:0] csum
);
  logic [19:0] acc;
  logic [16:0] s1;
  logic [15:0] s2;
  assign s1 = {1'b0, acc[15:0]} + {13'h0, acc[19:16]};
  assign s2 = s1[15:0] + {15'h0, s1[16]};
  assign csum = ~s2;
  // accumulate one header word per enabled cycle
  always_ff @(posedge clk)
    if (!rst_n || clr) acc <= '0;
    else if (add_en) acc <= acc + {4'h0, word};
endmodule

// File: rtl/wine_packet_composer.sv
// wine_packet_composer: assembles Ethernet/IPv4/TCP header word with IPv4 checksum
module wine_packet_composer
  import wine_pkg::*;
#(
  parameter logic [47:0] SRC_MAC = 48'h0,
  parameter logic [47:0] DST_MAC = 48'h0,
  parameter logic [15:0] ETH_TYPE = 16'h0800,
  parameter logic [7:0] DEFAULT_TTL = 8'd64
) (
  input logic clk,
  input logic rst_n,
  wine_packet_composer_if.slave bus
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] SUM = ST_SUM;
  localparam logic [1:0] FOLD = ST_FOLD;
  localparam logic [1:0] OUT = ST_OUT;
  logic [1:0] state;
  logic [3:0] idx;
  logic [15:0] ip_tag, tag_q, size_q, wind_q, csum;
  logic [103:0] tuple_q;
  logic [31:0] seq_q, ack_q;
  logic [5:0] flag_q;
  logic [79:0] payload_q;
  logic [511:0] pkt_q, pkt_d;
  logic [9:0][15:0] hw;
  logic accept;
  logic unused_flag_bits;
  assign unused_flag_bits = ^bus.tcp_flag[7:6];
  assign bus.i_ready = state == IDLE && rst_n;
  assign bus.o_valid = state == OUT;
  assign bus.o_packet = pkt_q;
  assign accept = bus.i_valid && bus.i_ready;
  assign hw = {tuple_q[55:40], tuple_q[71:56], tuple_q[87:72], tuple_q[103:88], 16'h0000,
               DEFAULT_TTL, tuple_q[7:0], IP_FLAG_DF, 13'h0, tag_q, size_q, IPV4_VER_IHL, 8'h00};
  assign pkt_d = {SRC_MAC, DST_MAC, ETH_TYPE, IPV4_VER_IHL, 8'h00, size_q, tag_q, IP_FLAG_DF, 13'h0,
                  DEFAULT_TTL, tuple_q[7:0], csum, tuple_q[103:8], seq_q, ack_q, 4'h5, 6'h0,
                  flag_q, wind_q, 32'h0, payload_q};
  wine_csum_acc u_acc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(accept),
    .add_en(state == SUM),
    .word(hw[idx]),
    .csum(csum)
  );
  // capture fields, walk the ten header words, latch the packet, hold until taken
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      ip_tag <= '0;
      tag_q <= '0;
      size_q <= '0;
      wind_q <= '0;
      tuple_q <= '0;
      seq_q <= '0;
      ack_q <= '0;
      flag_q <= '0;
      payload_q <= '0;
      pkt_q <= '0;
    end else if (accept) begin
      tuple_q <= bus.ip_tuple;
      size_q <= bus.pkt_size;
      seq_q <= bus.tcp_seq;
      ack_q <= bus.tcp_ack;
      flag_q <= bus.tcp_flag[5:0];
      wind_q <= bus.tcp_wind_size;
      payload_q <= bus.payload;
      tag_q <= ip_tag;
      ip_tag <= ip_tag + 16'd1;
      idx <= '0;
      state <= SUM;
    end else if (state == SUM) begin
      idx <= idx + 4'd1;
      state <= idx == 4'd9 ? FOLD : SUM;
    end else if (state == FOLD) begin
      pkt_q <= pkt_d;
      state <= OUT;
    end else if (state == OUT && bus.o_ready) begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_wine_packet_composer.sv
// tb_wine_packet_composer: directed scoreboard bench for the packet composer
module tb_wine_packet_composer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wine_packet_composer_if bus ();
  wine_packet_composer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [511:0] sb[$];
  logic [511:0] got, held;
  logic [15:0] tag_m = 16'h0;
  int n_cmp = 0;
  int n_err = 0;
  localparam logic [103:0] T1 = {32'hC0A80001, 32'hC0A800C7, 16'h1234, 16'h0050, 8'h11};
  localparam logic [103:0] T3 = {32'h0A000001, 32'h0A0000FE, 16'hBEEF, 16'h01BB, 8'h06};

  function automatic logic [15:0] model_csum(logic [15:0] size, logic [15:0] tag, logic [7:0] proto,
                                             logic [31:0] s, logic [31:0] d);
    int unsigned sum;
    sum = 32'h4500 + 32'(size) + 32'(tag) + 32'h4000 + 32'({8'd64, proto})
        + 32'(s[31:16]) + 32'(s[15:0]) + 32'(d[31:16]) + 32'(d[15:0]);
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    return ~sum[15:0];
  endfunction

  function automatic logic [511:0] model_pkt(logic [103:0] t, logic [15:0] size, logic [15:0] tag,
                                             logic [31:0] seq, logic [31:0] ack, logic [7:0] flag,
                                             logic [15:0] wind, logic [79:0] pay);
    return {48'h0, 48'h0, 16'h0800, 16'h4500, size, tag, 16'h4000, 8'd64, t[7:0],
            model_csum(size, tag, t[7:0], t[103:72], t[71:40]), t[103:8], seq, ack,
            4'h5, 6'h0, flag[5:0], wind, 32'h0, pay};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [103:0] t, input logic [15:0] size, input logic [31:0] seq,
                      input logic [31:0] ack, input logic [7:0] flag, input logic [15:0] wind,
                      input logic [79:0] pay);
    @(negedge clk);
    chk("i_ready_idle", 512'(bus.i_ready), 512'(1'b1));
    bus.ip_tuple = t;
    bus.pkt_size = size;
    bus.tcp_seq = seq;
    bus.tcp_ack = ack;
    bus.tcp_flag = flag;
    bus.tcp_wind_size = wind;
    bus.payload = pay;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    sb.push_back(model_pkt(t, size, tag_m, seq, ack, flag, wind, pay));
    tag_m++;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    chk({tag, "_latency"}, 512'(n), 512'(12));
    got = bus.o_packet;
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 512'(0), 512'(1));
    else chk({tag, "_packet"}, got, sb.pop_front());
  endtask

  task automatic take(input string tag);
    bus.o_ready = 1'b1;
    @(posedge clk);
    #1 bus.o_ready = 1'b0;
    chk({tag, "_o_valid_low"}, 512'(bus.o_valid), 512'(1'b0));
    chk({tag, "_i_ready_back"}, 512'(bus.i_ready), 512'(1'b1));
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    bus.ip_tuple = '0;
    bus.pkt_size = '0;
    bus.tcp_seq = '0;
    bus.tcp_ack = '0;
    bus.tcp_flag = '0;
    bus.tcp_wind_size = '0;
    bus.payload = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", 512'(bus.o_valid), 512'(1'b0));
    chk("rst_o_packet", bus.o_packet, 512'h0);
    chk("rst_i_ready", 512'(bus.i_ready), 512'(1'b0));
    rst_n = 1'b1;
    send(T1, 16'h0073, 32'h11111111, 32'h22222222, 8'h18, 16'h1000, 80'h0123456789ABCDEF0123);
    wait_out("p1");
    chk("p1_csum", 512'(got[319:304]), 512'(16'hB861));
    chk("p1_tag", 512'(got[367:352]), 512'(16'h0000));
    chk("p1_flag_offs", 512'(got[351:336]), 512'(16'h4000));
    take("p1");
    send(T1, 16'h0073, 32'h11111111, 32'h22222222, 8'h18, 16'h1000, 80'h0123456789ABCDEF0123);
    wait_out("p2");
    chk("p2_csum", 512'(got[319:304]), 512'(16'hB860));
    chk("p2_tag", 512'(got[367:352]), 512'(16'h0001));
    chk("rt_tuple", 512'({got[303:208], got[327:320]}), 512'(T1));
    chk("rt_pkt_size", 512'(got[383:368]), 512'(16'h0073));
    chk("rt_window", 512'(got[127:112]), 512'(16'h1000));
    chk("rt_flag", 512'({2'b00, got[133:128]}), 512'(8'h18 & 8'h3F));
    take("p2");
    send(T3, 16'h05DC, 32'hDEADBEEF, 32'h0BADF00D, 8'h12, 16'h7210, 80'h0);
    wait_out("stall");
    held = got;
    for (int i = 0; i < 20; i++) begin
      bus.i_valid = i[0];
      @(negedge clk);
      chk("stall_o_valid", 512'(bus.o_valid), 512'(1'b1));
      chk("stall_o_packet", bus.o_packet, held);
      chk("stall_i_ready", 512'(bus.i_ready), 512'(1'b0));
    end
    bus.i_valid = 1'b0;
    take("stall");
    send(T3, 16'h0028, 32'h0, 32'h0, 8'hFF, 16'hFFFF, '1);
    wait_out("ones");
    chk("ones_flag", 512'(got[133:128]), 512'(6'h3F));
    chk("ones_hdr", 512'(got[143:140]), 512'(4'h5));
    chk("ones_resv", 512'(got[139:134]), 512'(6'h0));
    chk("ones_csum_urg", 512'(got[111:80]), 512'(32'h0));
    chk("ones_payload", 512'(got[79:0]), 512'({80{1'b1}}));
    take("ones");
    send(T3, 16'h0100, 32'h5, 32'h6, 8'h02, 16'h0400, 80'h77);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    chk("midrst_i_ready", 512'(bus.i_ready), 512'(1'b0));
    @(negedge clk);
    chk("midrst_o_valid", 512'(bus.o_valid), 512'(1'b0));
    chk("midrst_o_packet", bus.o_packet, 512'h0);
    rst_n = 1'b1;
    sb.delete();
    tag_m = 16'h0;
    repeat (14) @(negedge clk);
    chk("midrst_no_output", 512'(bus.o_valid), 512'(1'b0));
    send(T1, 16'h0073, 32'h11111111, 32'h22222222, 8'h18, 16'h1000, 80'h0123456789ABCDEF0123);
    wait_out("p5");
    chk("p5_csum", 512'(got[319:304]), 512'(16'hB861));
    chk("p5_tag", 512'(got[367:352]), 512'(16'h0000));
    take("p5");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
